// File: rtl/riscv_structures_pkg.sv
// Shared RISC-V decode types: instruction format classes, opcode map,
// occupancy states and the decoded-entry record held by the decode stage.
package riscv_structures;

  typedef enum logic [2:0] {
    R_TYPE       = 3'd0,
    I_TYPE       = 3'd1,
    S_TYPE       = 3'd2,
    B_TYPE       = 3'd3,
    U_TYPE       = 3'd4,
    J_TYPE       = 3'd5,
    INVALID_TYPE = 3'd6
  } instr_type_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    instr_type_e itype;
    logic        illegal;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [24:0] instr_hi;
  } decoded_entry_t;

  // Empty slot contents: idle type class, not illegal, all fields zero.
  function automatic decoded_entry_t blank_entry(input instr_type_e idle_type);
    decoded_entry_t e;
    e = '0;
    e.itype = idle_type;
    e.illegal = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational opcode classification and fixed-position field extraction.
module instr_decoder
  import riscv_structures::*;
(
  input  logic [31:0]    instr,
  output decoded_entry_t entry
);

  // Classify the opcode; a non-32-bit encoding (instr[1:0] != 11) is always illegal.
  always_comb begin
    entry          = '0;
    entry.opcode   = instr[6:0];
    entry.rd       = instr[11:7];
    entry.funct3   = instr[14:12];
    entry.rs1      = instr[19:15];
    entry.rs2      = instr[24:20];
    entry.funct7   = instr[31:25];
    entry.instr_hi = instr[31:7];
    entry.itype    = INVALID_TYPE;
    entry.illegal  = 1'b1;
    if (instr[1:0] == 2'b11) begin
      entry.illegal = 1'b0;
      case (instr[6:0])
        OPC_OP:                  entry.itype = R_TYPE;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR,
        OPC_SYSTEM, OPC_MISC_MEM: entry.itype = I_TYPE;
        OPC_STORE:               entry.itype = S_TYPE;
        OPC_BRANCH:              entry.itype = B_TYPE;
        OPC_LUI, OPC_AUIPC:      entry.itype = U_TYPE;
        OPC_JAL:                 entry.itype = J_TYPE;
        default: begin
          entry.itype   = INVALID_TYPE;
          entry.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched word, then buffers it in an output
// register backed by a skid register so in_ready can be registered while
// still sustaining one instruction per cycle.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  OCC_EMPTY | nothing held, out_valid=0, in_ready=1
//  OCC_ONE   | output register holds an entry, skid empty, in_ready=1
//  OCC_TWO   | both output and skid registers full, in_ready=0
module decode_stage
  import riscv_structures::*;
#(
  parameter int          XLEN       = 32,
  parameter instr_type_e RESET_TYPE = INVALID_TYPE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output instr_type_e     out_instr_type,
  output logic [24:0]     out_instr,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  occ_state_e     state;
  decoded_entry_t dec;
  decoded_entry_t out_q;
  decoded_entry_t skid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] skid_pc_q;
  logic            in_fire;
  logic            out_fire;

  instr_decoder u_decoder (
    .instr (in_instr[31:0]),
    .entry (dec)
  );

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Occupancy FSM with registered in_ready/out_valid; flush empties both slots.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= OCC_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= blank_entry(RESET_TYPE);
      skid_q    <= blank_entry(RESET_TYPE);
      out_pc_q  <= '0;
      skid_pc_q <= '0;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            out_q     <= dec;
            out_pc_q  <= in_pc;
            out_valid <= 1'b1;
            state     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            out_q    <= dec;
            out_pc_q <= in_pc;
          end else if (in_fire) begin
            skid_q    <= dec;
            skid_pc_q <= in_pc;
            in_ready  <= 1'b0;
            state     <= OCC_TWO;
          end else if (out_fire) begin
            out_q     <= blank_entry(RESET_TYPE);
            out_pc_q  <= '0;
            out_valid <= 1'b0;
            state     <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            out_q     <= skid_q;
            out_pc_q  <= skid_pc_q;
            skid_q    <= blank_entry(RESET_TYPE);
            skid_pc_q <= '0;
            in_ready  <= 1'b1;
            state     <= OCC_ONE;
          end
        end
        default: begin
          state     <= OCC_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_instr_type = out_q.itype;
  assign out_illegal    = out_q.illegal;
  assign out_instr      = out_q.instr_hi;
  assign out_opcode     = out_q.opcode;
  assign out_rd         = out_q.rd;
  assign out_rs1        = out_q.rs1;
  assign out_rs2        = out_q.rs2;
  assign out_funct3     = out_q.funct3;
  assign out_funct7     = out_q.funct7;
  assign out_pc         = out_pc_q;

endmodule
